// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants for the pipeline sequencing controller:
//               register address width, FSM state encodings, link register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REGAW = 4;
    localparam int NREGS = 16;
    localparam int CNTW  = 2;

    localparam logic [REGAW-1:0] LR_IDX = 4'd14;
    localparam logic [REGAW-1:0] PC_IDX = 4'd15;

    localparam logic [1:0] PC_RUN = 2'd0;
    localparam logic [1:0] PC_BR1 = 2'd1;
    localparam logic [1:0] PC_BR2 = 2'd2;

    // The counter holds the cycles still to wait after the issue cycle itself,
    // so a consumer in cycle issue+WB_LAT sees the register as free.
    function automatic logic [CNTW-1:0] wb_cnt_init(input int lat);
        return CNTW'(lat - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_reg_scoreboard.sv
//==============================================================================
// Module      : reg_scoreboard
// Description : Per-register write-back countdowns plus outstanding-load
//               tracking; busy lookups for three read ports and r14.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REGAW-1:0] rd_a,
    input  logic [REGAW-1:0] rd_b,
    input  logic [REGAW-1:0] rd_c,
    input  logic             alu_set,
    input  logic [REGAW-1:0] alu_rd,
    input  logic             lr_set,
    input  logic             ld_issue,
    input  logic [REGAW-1:0] ld_rd_in,
    input  logic             mem_ready,
    output logic             busy_a,
    output logic             busy_b,
    output logic             busy_c,
    output logic             busy_lr,
    output logic             ld_pend
);

    localparam logic [CNTW-1:0] c_cnt_init = wb_cnt_init(WB_LAT);

    logic             r_ld_pend;
    logic [REGAW-1:0] r_ld_rd;
    logic [NREGS-1:0] w_reg_busy;

    // A new load can only issue while none is pending, so set and clear
    // never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_pend <= 1'b0;
            r_ld_rd   <= '0;
        end else if (ld_issue) begin
            r_ld_pend <= 1'b1;
            r_ld_rd   <= ld_rd_in;
        end else if (mem_ready && r_ld_pend) begin
            r_ld_pend <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (REGAW'(gi) == PC_IDX) begin : g_pc
            assign w_reg_busy[gi] = 1'b0;
        end else begin : g_gpr
            logic [CNTW-1:0] r_cnt;
            logic            w_set;

            assign w_set = (alu_set && (alu_rd == REGAW'(gi))) ||
                           (lr_set  && (REGAW'(gi) == LR_IDX));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_set) begin
                    r_cnt <= c_cnt_init;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_reg_busy[gi] = (r_cnt != '0) ||
                                    (r_ld_pend && (r_ld_rd == REGAW'(gi)));
        end
    end

    assign busy_a  = w_reg_busy[rd_a];
    assign busy_b  = w_reg_busy[rd_b];
    assign busy_c  = w_reg_busy[rd_c];
    assign busy_lr = w_reg_busy[LR_IDX];
    assign ld_pend = r_ld_pend;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// Module      : pipe_ctrl
// Description : Decode-stage issue/stall/kill controller with register
//               scoreboard and branch-shadow FSM. Option macro: PIPE_FWD_EN
//               (ALU results forwarded; only load hazards stall).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WB_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REGAW-1:0] id_rn,
    input  logic [REGAW-1:0] id_rm,
    input  logic [REGAW-1:0] id_rd,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             id_reg_we,
    input  logic             id_is_load,
    input  logic             id_ib,
    input  logic             id_bl,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             ispb,
    output logic             stall
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic w_busy_rn;
    logic w_busy_rm;
    logic w_busy_rd;
    logic w_busy_lr;
    logic w_ld_pend;
    logic w_hazard;
    logic w_issue;
    logic w_alu_set;
    logic w_lr_set;
    logic w_ld_issue;

    assign w_hazard = id_valid && ((id_uses_rn && w_busy_rn) ||
                                   (id_uses_rm && w_busy_rm) ||
                                   (id_reg_we  && w_busy_rd) ||
                                   (id_bl      && w_busy_lr) ||
                                   (id_is_load && w_ld_pend));

    assign w_issue    = (r_state == PC_RUN) && id_valid && !w_hazard;
    assign w_ld_issue = w_issue && id_is_load;

`ifdef PIPE_FWD_EN
    assign w_alu_set = 1'b0;
    assign w_lr_set  = 1'b0;
`else
    assign w_alu_set = w_issue && id_reg_we && !id_is_load;
    assign w_lr_set  = w_issue && id_bl;
`endif

    reg_scoreboard #(
        .WB_LAT    (WB_LAT)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_a      (id_rn),
        .rd_b      (id_rm),
        .rd_c      (id_rd),
        .alu_set   (w_alu_set),
        .alu_rd    (id_rd),
        .lr_set    (w_lr_set),
        .ld_issue  (w_ld_issue),
        .ld_rd_in  (id_rd),
        .mem_ready (mem_ready),
        .busy_a    (w_busy_rn),
        .busy_b    (w_busy_rm),
        .busy_c    (w_busy_rd),
        .busy_lr   (w_busy_lr),
        .ld_pend   (w_ld_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PC_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Branch shadow: the two fetched-behind instructions are killed while
    // fetch keeps running toward the target.
    always_comb begin
        w_state_nxt = r_state;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b1;
        ispb        = 1'b0;
        stall       = 1'b0;
        case (r_state)
            PC_RUN: begin
                stall       = w_hazard;
                pc_we       = !w_hazard;
                ifid_we     = !w_hazard;
                idex_bubble = !w_issue;
                if (w_issue && id_ib) begin
                    w_state_nxt = PC_BR1;
                end
            end
            PC_BR1: begin
                ispb        = 1'b1;
                w_state_nxt = PC_BR2;
            end
            PC_BR2: begin
                ispb        = 1'b1;
                w_state_nxt = PC_RUN;
            end
            default: begin
                w_state_nxt = PC_RUN;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//==============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl against a cycle-count
//               reference model. Honours PIPE_FWD_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int WB_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REGAW-1:0] id_rn, id_rm, id_rd;
    logic             id_uses_rn, id_uses_rm, id_reg_we, id_is_load, id_ib, id_bl;
    logic             mem_ready;
    logic             pc_we, ifid_we, idex_bubble, ispb, stall;
    logic [4:0]       outs;

    pipe_ctrl #(.WB_LAT(WB_LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_reg_we(id_reg_we), .id_is_load(id_is_load),
        .id_ib(id_ib), .id_bl(id_bl), .mem_ready(mem_ready),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_bubble(idex_bubble),
        .ispb(ispb), .stall(stall)
    );

    always #5 clk = ~clk;

    assign outs = {pc_we, ifid_we, idex_bubble, ispb, stall};

    typedef struct packed {
        logic       v;
        logic [3:0] rn, rm, rd;
        logic       urn, urm, we, ld, ib, bl;
    } ins_t;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PIPE_FWD_EN
    bit fwd = 1'b1;
`else
    bit fwd = 1'b0;
`endif

    // Model: absolute cycle at which each register's ALU result is readable,
    // the pending load, and remaining killed cycles after a branch.
    int cyc = 0;
    int avail[16];
    bit m_ld_pend;
    int m_ld_rd;
    int shadow;
    ins_t NOP = '0;

    function automatic ins_t mk(logic v, logic [3:0] rn, logic [3:0] rm, logic [3:0] rd,
                                logic urn, logic urm, logic we, logic ld, logic ib, logic bl);
        ins_t x;
        x = {v, rn, rm, rd, urn, urm, we, ld, ib, bl};
        return x;
    endfunction

    task automatic drive(input ins_t x);
        id_valid = x.v;  id_rn = x.rn;  id_rm = x.rm;  id_rd = x.rd;
        id_uses_rn = x.urn;  id_uses_rm = x.urm;  id_reg_we = x.we;
        id_is_load = x.ld;   id_ib = x.ib;        id_bl = x.bl;
    endtask

    function automatic bit mbusy(int r);
        if (r == 15) return 1'b0;
        return (avail[r] > cyc) || (m_ld_pend && m_ld_rd == r);
    endfunction

    function automatic bit m_hazard();
        return id_valid && ((id_uses_rn && mbusy(int'(id_rn))) ||
                            (id_uses_rm && mbusy(int'(id_rm))) ||
                            (id_reg_we  && mbusy(int'(id_rd))) ||
                            (id_bl      && mbusy(14)) ||
                            (id_is_load && m_ld_pend));
    endfunction

    function automatic logic [4:0] model_out();
        bit h;
        if (shadow > 0) return 5'b11110;
        h = m_hazard();
        return {!h, !h, !(id_valid && !h), 1'b0, h};
    endfunction

    task automatic model_update();
        bit iss;
        iss = (shadow == 0) && id_valid && !m_hazard();
        if (shadow > 0) shadow--;
        if (mem_ready && m_ld_pend) m_ld_pend = 1'b0;
        if (iss) begin
            if (id_ib) shadow = 2;
            if (!fwd) begin
                if (id_reg_we && !id_is_load) avail[id_rd] = cyc + WB_LAT;
                if (id_bl) avail[14] = cyc + WB_LAT;
            end
            if (id_is_load) begin
                m_ld_pend = 1'b1;
                m_ld_rd   = int'(id_rd);
            end
        end
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) avail[i] = 0;
        m_ld_pend = 1'b0;
        m_ld_rd   = 0;
        shadow    = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(NOP);
            mem_ready = 1'b1;
            @(posedge clk);
            model_update();
        end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst = 1'b1;
        drive(NOP);
        mem_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (outs !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", outs, 5'b11100);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        exp = model_out();
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", outs, exp);
        end
        @(posedge clk);
        model_update();
    endtask

    task automatic test_independent();
        logic [4:0] exp;
        idle(4);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(mk(1, 4'(8 + i % 4), 4'd13, 4'(i % 6), 1, 1, 1, 0, 0, 0));
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL indep_outs cyc %0d: got %b want %b", cyc, outs, exp);
            end
            n_checks++;
            if (stall !== 1'b0 || idex_bubble !== 1'b0) begin
                n_fail++;
                $display("FAIL indep_issue cyc %0d: stall=%b bubble=%b want 0 0", cyc, stall, idex_bubble);
            end
            @(posedge clk);
            model_update();
        end
    endtask

    task automatic test_raw();
        logic [4:0] exp;
        int stalls = 0;
        bit done = 1'b0;
        idle(4);
        @(negedge clk);
        drive(mk(1, 4'd8, 4'd0, 4'd3, 1, 0, 1, 0, 0, 0));
        #1;
        exp = model_out();
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL raw_producer: got %b want %b", outs, exp);
        end
        @(posedge clk);
        model_update();
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            drive(mk(1, 4'd3, 4'd0, 4'd9, 1, 0, 1, 0, 0, 0));
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL raw_outs cyc %0d: got %b want %b", cyc, outs, exp);
            end
            if (stall === 1'b1) stalls++;
            else done = 1'b1;
            @(posedge clk);
            model_update();
        end
        n_checks++;
        if (stalls != (fwd ? 0 : WB_LAT - 1)) begin
            n_fail++;
            $display("FAIL raw_stall_count: got %0d want %0d", stalls, fwd ? 0 : WB_LAT - 1);
        end
    endtask

    task automatic test_load_use();
        logic [4:0] exp;
        int stalls = 0;
        bit done = 1'b0;
        idle(4);
        @(negedge clk);
        drive(mk(1, 4'd12, 4'd0, 4'd5, 1, 0, 1, 1, 0, 0));
        #1;
        exp = model_out();
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL ldr_issue: got %b want %b", outs, exp);
        end
        @(posedge clk);
        model_update();
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            drive(mk(1, 4'd5, 4'd0, 4'd6, 1, 0, 1, 0, 0, 0));
            mem_ready = (k == 4);
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL load_use_outs cyc %0d: got %b want %b", cyc, outs, exp);
            end
            if (stall === 1'b1) stalls++;
            else done = 1'b1;
            @(posedge clk);
            model_update();
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (stalls != 5) begin
            n_fail++;
            $display("FAIL load_use_stall_count: got %0d want 5", stalls);
        end
    endtask

    task automatic test_branch();
        logic [4:0] exp;
        logic [3:0] ispb_seen;
        logic [3:0] ispb_want;
        ispb_want = 4'b0110;
        idle(4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drive(mk(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0));
            else        drive(mk(1, 4'd10, 4'd11, 4'd2, 1, 1, 1, 0, 0, 0));
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL branch_outs k=%0d: got %b want %b", k, outs, exp);
            end
            ispb_seen[k] = ispb;
            @(posedge clk);
            model_update();
        end
        n_checks++;
        if (ispb_seen !== ispb_want) begin
            n_fail++;
            $display("FAIL branch_ispb_seq: got %b want %b", ispb_seen, ispb_want);
        end
    endtask

    task automatic test_bl();
        logic [4:0] exp;
        int stalls = 0;
        bit done = 1'b0;
        idle(4);
        @(negedge clk);
        drive(mk(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1));
        #1;
        exp = model_out();
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL bl_issue: got %b want %b", outs, exp);
        end
        @(posedge clk);
        model_update();
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            drive(mk(1, 4'd14, 4'd0, 4'd0, 1, 0, 0, 0, 0, 0));
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL bl_r14_outs cyc %0d: got %b want %b", cyc, outs, exp);
            end
            if (stall === 1'b1) stalls++;
            else done = 1'b1;
            @(posedge clk);
            model_update();
        end
        n_checks++;
        if (stalls != (fwd ? 0 : WB_LAT - 1)) begin
            n_fail++;
            $display("FAIL bl_stall_count: got %0d want %0d", stalls, fwd ? 0 : WB_LAT - 1);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        idle(4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0)      drive(mk(1, 4'd12, 4'd0, 4'd7, 1, 0, 1, 1, 0, 0));
            else if (k == 1) drive(mk(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0));
            else             drive(NOP);
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL rstmid_pre k=%0d: got %b want %b", k, outs, exp);
            end
            if (k < 2) begin
                @(posedge clk);
                model_update();
            end
        end
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (outs !== 5'b11100) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b want %b", outs, 5'b11100);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 4'd7, 4'd0, 4'd8, 1, 0, 1, 1, 0, 0));
        #1;
        exp = model_out();
        n_checks++;
        if (outs !== exp || stall !== 1'b0 || ispb !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got %b want %b", outs, exp);
        end
        @(posedge clk);
        model_update();
    endtask

    task automatic test_random();
        logic [4:0] exp;
        logic [3:0] pick [6];
        pick[0] = 4'd0; pick[1] = 4'd1; pick[2] = 4'd2;
        pick[3] = 4'd3; pick[4] = 4'd14; pick[5] = 4'd15;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            drive(mk($urandom_range(0, 3) != 0,
                     pick[$urandom_range(0, 5)], pick[$urandom_range(0, 5)],
                     pick[$urandom_range(0, 5)],
                     1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0));
            mem_ready = ($urandom_range(0, 3) == 0);
            #1;
            exp = model_out();
            n_checks++;
            if (outs !== exp) begin
                n_fail++;
                $display("FAIL random_outs cyc %0d: got %b want %b", cyc, outs, exp);
            end
            @(posedge clk);
            model_update();
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_load_use();
        test_branch();
        test_bl();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
